sms_sample_capture_latch: RTL and testbench

Downstream consumer of the SDTRL sample-pulse generator. It detects the rising edge of the sample pulse and captures the parallel data word (including its check bit) into a holding register. It then presents the word to the next stage through a valid/ack handshake. It also flags odd-parity errors, overruns (a new sample arriving before the held word was taken) and stuck sample pulses.

---
 rtl/sms_pkg.sv | 14 +
 rtl/sms_pulse_width_monitor.sv | 41 ++++
 rtl/sms_sample_capture_latch.sv | 75 +++++++
 tb/tb_sms_sample_capture_latch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sms_pkg.sv
// Constants shared across the SMS sample path
// (pulse generator, width monitor and capture latch).
package sms_pkg;

  localparam logic        SMS_ODD_PARITY   = 1'b1;
  localparam int unsigned SMS_SAMPLE_WIDTH = 4;
  localparam int unsigned SMS_MAX_WIDTH    = 2 * SMS_SAMPLE_WIDTH;

  // Takes the XOR-reduction of a word; returns 1 when the word breaks the configured parity.
  function automatic logic parity_fault(input logic word_xor);
    return word_xor ^ SMS_ODD_PARITY;
  endfunction

endpackage

// File: rtl/sms_pulse_width_monitor.sv
// Rising-edge detector and saturating high-time counter for an SMS pulse line.
// Flags the cycle on which the pulse has stayed high for more than MAX_WIDTH cycles.
module sms_pulse_width_monitor
  import sms_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = SMS_MAX_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse,
  output logic rise,
  output logic stuck_set
);

  localparam int unsigned CW = $clog2(MAX_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WIDTH);

  logic          pulse_d;
  logic [CW-1:0] cnt;

  // pulse_d resets high so a pulse already in flight at reset release is not seen as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_d <= 1'b1;
      cnt     <= '0;
    end else begin
      pulse_d <= pulse;
      if (!pulse) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    rise      = pulse & ~pulse_d;
    stuck_set = pulse & (cnt == CNT_MAX);
  end

endmodule

// File: rtl/sms_sample_capture_latch.sv
// Captures the data word on each sample rising edge and hands it downstream
// over valid/ack, with parity, overrun and stuck-pulse reporting.
module sms_sample_capture_latch
  import sms_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_WIDTH = SMS_MAX_WIDTH
) (
  input  logic             x,
  input  logic             reset_n,
  input  logic             sample,
  input  logic [WIDTH-1:0] data,
  input  logic             ack,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             parity_err,
  output logic             overrun,
  output logic             stuck
);

  logic rise;
  logic stuck_set;
  logic capture;
  logic drop;
  logic release_word;

  sms_pulse_width_monitor #(
    .MAX_WIDTH(MAX_WIDTH)
  ) u_mon (
    .clk      (x),
    .rst_n    (reset_n),
    .pulse    (sample),
    .rise     (rise),
    .stuck_set(stuck_set)
  );

  // An ack on the same edge as a new rise frees the slot, so the new word is taken
  always_comb begin
    capture      = rise & (~valid | ack);
    drop         = rise & valid & ~ack;
    release_word = ~rise & valid & ack;
  end

  always_ff @(posedge x or negedge reset_n) begin
    if (!reset_n) begin
      q          <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      if (capture) begin
        q          <= data;
        valid      <= 1'b1;
        parity_err <= parity_fault(^data);
      end else if (release_word) begin
        valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end

      if (stuck_set) begin
        stuck <= 1'b1;
      end else if (clr_err) begin
        stuck <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sms_sample_capture_latch.sv
// Scenario bench for sms_sample_capture_latch; words expected downstream are queued
// when the capturing pulse is driven and popped when the bench accepts them with ack.
module tb_sms_sample_capture_latch;

  logic       x = 1'b0;
  logic       reset_n;
  logic       sample;
  logic [7:0] data;
  logic       ack;
  logic       clr_err;
  logic [7:0] q;
  logic       valid;
  logic       parity_err;
  logic       overrun;
  logic       stuck;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       perr;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  sms_sample_capture_latch #(
    .WIDTH    (8),
    .MAX_WIDTH(8)
  ) dut (
    .x         (x),
    .reset_n   (reset_n),
    .sample    (sample),
    .data      (data),
    .ack       (ack),
    .clr_err   (clr_err),
    .q         (q),
    .valid     (valid),
    .parity_err(parity_err),
    .overrun   (overrun),
    .stuck     (stuck)
  );

  always #5 x = ~x;

  task automatic tick();
    @(posedge x);
    #1;
  endtask

  // Odd parity: a word with an even count of ones is an error
  task automatic push_exp(input logic [7:0] d);
    exp_t t;
    t.d    = d;
    t.perr = ~^d;
    sb.push_back(t);
  endtask

  task automatic pop_and_accept(input string tag);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: no expected word queued, q=%h valid=%b", tag, q, valid);
    end else begin
      e = sb.pop_front();
      if (q !== e.d || parity_err !== e.perr || valid !== 1'b1) begin
        errors++;
        $display("FAIL %s_sb: got q=%h perr=%b valid=%b exp q=%h perr=%b valid=1",
                 tag, q, parity_err, valid, e.d, e.perr);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL %s_ack: valid got %b exp 0", tag, valid); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sample = 1'b0; data = '0; ack = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge x);
    #3 reset_n = 1'b1;
    tick();
    checks++;
    if ({q, valid, parity_err, overrun, stuck} !== 12'h000) begin
      errors++;
      $display("FAIL reset: got q=%h v=%b p=%b o=%b s=%b exp all 0", q, valid, parity_err, overrun, stuck);
    end
  endtask

  task automatic test_capture();
    sample = 1'b1; data = 8'h83; push_exp(8'h83);
    tick();
    checks++;
    if (q !== 8'h83 || valid !== 1'b1 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL cap_first: got q=%h v=%b p=%b exp q=83 v=1 p=0", q, valid, parity_err);
    end
    repeat (3) tick();
    sample = 1'b0; data = 8'hff;
    tick();
    checks++;
    if (q !== 8'h83 || valid !== 1'b1 || overrun !== 1'b0 || stuck !== 1'b0) begin
      errors++;
      $display("FAIL cap_hold: got q=%h v=%b o=%b s=%b exp q=83 v=1 o=0 s=0", q, valid, overrun, stuck);
    end
  endtask

  task automatic test_overrun();
    sample = 1'b1; data = 8'h01;
    tick();
    checks++;
    if (q !== 8'h83 || valid !== 1'b1 || overrun !== 1'b1 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL ovr_set: got q=%h v=%b o=%b p=%b exp q=83 v=1 o=1 p=0", q, valid, overrun, parity_err);
    end
    repeat (3) tick();
    sample = 1'b0;
    tick();
    pop_and_accept("ovr");
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b exp 1", overrun); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b exp 0", overrun); end
  endtask

  task automatic test_back_to_back();
    sample = 1'b1; data = 8'ha7; push_exp(8'ha7);
    tick();
    sample = 1'b0;
    tick();
    checks++;
    if (q !== 8'ha7 || valid !== 1'b1 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got q=%h v=%b p=%b exp q=a7 v=1 p=0", q, valid, parity_err);
    end
    checks++;
    e = sb.pop_front();
    if (q !== e.d) begin errors++; $display("FAIL b2b_sb: got q=%h exp %h", q, e.d); end
    ack = 1'b1; sample = 1'b1; data = 8'h03; push_exp(8'h03);
    tick();
    ack = 1'b0;
    checks++;
    if (q !== 8'h03 || valid !== 1'b1 || parity_err !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack_rise: got q=%h v=%b p=%b o=%b exp q=03 v=1 p=1 o=0", q, valid, parity_err, overrun);
    end
    sample = 1'b0;
    tick();
    pop_and_accept("b2b");
  endtask

  task automatic test_stuck();
    sample = 1'b1; data = 8'h15; push_exp(8'h15);
    tick();
    checks++;
    if (q !== 8'h15 || valid !== 1'b1 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL stk_cap: got q=%h v=%b p=%b exp q=15 v=1 p=0", q, valid, parity_err);
    end
    repeat (7) tick();
    checks++;
    if (stuck !== 1'b0) begin errors++; $display("FAIL stk_early: after 8 high edges got %b exp 0", stuck); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (stuck !== 1'b1) begin errors++; $display("FAIL stk_set: 9th edge with clr got %b exp 1", stuck); end
    sample = 1'b0;
    tick();
    checks++;
    if (overrun !== 1'b0 || stuck !== 1'b1 || q !== 8'h15) begin
      errors++;
      $display("FAIL stk_single: got o=%b s=%b q=%h exp o=0 s=1 q=15", overrun, stuck, q);
    end
    pop_and_accept("stk");
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (stuck !== 1'b0) begin errors++; $display("FAIL stk_clr: got %b exp 0", stuck); end
  endtask

  task automatic test_pulse_across_reset();
    reset_n = 1'b0; sample = 1'b1; data = 8'h55;
    repeat (2) @(posedge x);
    #3 reset_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (valid !== 1'b0 || stuck !== 1'b0 || q !== 8'h00) begin
      errors++;
      $display("FAIL rst_pulse_ignored: got v=%b s=%b q=%h exp v=0 s=0 q=00", valid, stuck, q);
    end
    sample = 1'b0;
    tick();
    sample = 1'b1; data = 8'h80; push_exp(8'h80);
    tick();
    checks++;
    if (q !== 8'h80 || valid !== 1'b1 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_clean_cap: got q=%h v=%b p=%b exp q=80 v=1 p=0", q, valid, parity_err);
    end
    sample = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    sample = 1'b1; data = 8'h01;
    tick();
    checks++;
    if (overrun !== 1'b1 || valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: got o=%b v=%b exp o=1 v=1", overrun, valid);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({q, valid, parity_err, overrun, stuck} !== 12'h000) begin
      errors++;
      $display("FAIL arst_now: got q=%h v=%b p=%b o=%b s=%b exp all 0", q, valid, parity_err, overrun, stuck);
    end
    sb.delete();
    sample = 1'b0;
    @(posedge x);
    #3 reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_overrun();
    test_back_to_back();
    test_stuck();
    test_pulse_across_reset();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d words left exp 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
